// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a single shared memory bus.
// m0 is the instruction-fetch port and m1 the data port; a stalled slave is aborted after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// BUSY  | one master granted; bus driven from its fields, waiting for bus_ready
// TURN  | one-cycle gap after completion so the served master can drop req
module mem_bus_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic [3:0]       m0_byteen,
    output logic             m0_ack,
    output logic             m0_err,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    input  logic [3:0]       m1_byteen,
    output logic             m1_ack,
    output logic             m1_err,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_data_in,
    output logic             bus_we,
    output logic             bus_re,
    output logic [3:0]       bus_byteen,
    input  logic [WIDTH-1:0] bus_data_out,
    input  logic             bus_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TURN = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       grant;       // 0 = m0, 1 = m1; meaningful only in BUSY
    logic       last_grant;
    logic [7:0] tmo_cnt;

    logic             busy;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic [3:0]       sel_byteen;
    logic             done_ok;
    logic             done_tmo;

    always_comb begin
        busy       = (state == S_BUSY);
        sel_we     = grant ? m1_we     : m0_we;
        sel_addr   = grant ? m1_addr   : m0_addr;
        sel_wdata  = grant ? m1_wdata  : m0_wdata;
        sel_byteen = grant ? m1_byteen : m0_byteen;
    end

    // Ready takes priority over an expiring timeout in the same cycle.
    always_comb begin
        done_ok  = busy & bus_ready;
        done_tmo = busy & ~bus_ready & (tmo_cnt == TMO_LAST);
    end

    // Bus and handshake outputs are gated by BUSY so reset clears them immediately.
    always_comb begin
        bus_addr    = busy ? sel_addr   : '0;
        bus_data_in = busy ? sel_wdata  : '0;
        bus_byteen  = busy ? sel_byteen : 4'b0000;
        bus_we      = busy & sel_we;
        bus_re      = busy & ~sel_we;
        m0_ack      = done_ok  & ~grant;
        m1_ack      = done_ok  &  grant;
        m0_err      = done_tmo & ~grant;
        m1_err      = done_tmo &  grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            tmo_cnt    <= 8'd0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        grant   <= (m0_req && m1_req) ? ~last_grant : m1_req;
                        tmo_cnt <= 8'd0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (done_ok) begin
                        if (!sel_we) begin
                            if (grant) m1_rdata <= bus_data_out;
                            else       m0_rdata <= bus_data_out;
                        end
                        last_grant <= grant;
                        state      <= S_TURN;
                    end else if (done_tmo) begin
                        last_grant <= grant;
                        state      <= S_TURN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_TURN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table-driven cycle vectors plus hand-written
// corner sequences; read data is checked against a queue of expected completions.
module tb_mem_bus_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m0_req = 1'b0, m1_req = 1'b0;
    logic         m0_we = 1'b0, m1_we = 1'b0;
    logic [W-1:0] m0_addr = 32'h100, m1_addr = 32'h200;
    logic [W-1:0] m0_wdata = 32'h0BAD0000, m1_wdata = 32'h0BAD0001;
    logic [3:0]   m0_byteen = 4'hF, m1_byteen = 4'hF;
    logic         m0_ack, m1_ack, m0_err, m1_err;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic [W-1:0] bus_addr, bus_data_in, bus_data_out = '0;
    logic         bus_we, bus_re, bus_ready = 1'b0;
    logic [3:0]   bus_byteen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WIDTH(W), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byteen(m0_byteen), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byteen(m1_byteen), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_data_in(bus_data_in), .bus_we(bus_we), .bus_re(bus_re),
        .bus_byteen(bus_byteen), .bus_data_out(bus_data_out), .bus_ready(bus_ready)
    );

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Expected read completions: which master and the data it must hold afterwards.
    typedef struct {
        logic         m;
        logic [W-1:0] d;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;
    logic sb_m;

    always @(posedge clk) begin
        if (rst_n && (m0_ack || m1_ack) && bus_re) begin
            sb_m = m1_ack;
            #1;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_read", {31'd0, sb_m}, 32'hFFFFFFFF);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_master", {31'd0, sb_m}, {31'd0, sb_e.m});
                chk("sb_rdata", sb_m ? m1_rdata : m0_rdata, sb_e.d);
            end
        end
    end

    task automatic push_rd(input logic m, input logic [W-1:0] d);
        sb_t e;
        e.m = m;
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic rdy, input logic [W-1:0] d);
        @(negedge clk);
        m0_req = r0; m1_req = r1; bus_ready = rdy; bus_data_out = d;
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic         r0, r1, rdy;
        logic [W-1:0] dout;
        logic         e_re, e_a0, e_a1;
        logic [W-1:0] e_addr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1, input logic rdy,
                                input logic [W-1:0] d, input logic ere, input logic ea0,
                                input logic ea1, input logic [W-1:0] eaddr);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.dout = d;
        v.e_re = ere; v.e_a0 = ea0; v.e_a1 = ea1; v.e_addr = eaddr;
        return v;
    endfunction

    initial begin
        // Single m0 read with zero wait states: IDLE, BUSY(ack), TURN, IDLE.
        tbl.push_back(mk(1, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'hDEADBEEF, 1, 1, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 1, 32'h11111111, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h22222222, 0, 0, 0, 32'h0));
        // Both masters held after reset: grants alternate m0, m1, m0, m1.
        for (int i = 0; i < 12; i++) begin
            case (i % 6)
                1:       tbl.push_back(mk(i == 0, 1, 1, 1, 32'hA0 + i, 1, 1, 0, 32'h100));
                4:       tbl.push_back(mk(i == 0, 1, 1, 1, 32'hA0 + i, 1, 0, 1, 32'h200));
                default: tbl.push_back(mk(i == 0, 1, 1, 1, 32'hA0 + i, 0, 0, 0, 32'h0));
            endcase
        end
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));

        // Outputs during reset, even with a request pending.
        m0_req = 1'b1; bus_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_re", {31'd0, bus_re}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_byteen", {28'd0, bus_byteen}, 32'd0);
        chk("rst_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cyc(tbl[i].r0, tbl[i].r1, tbl[i].rdy, tbl[i].dout);
            chk($sformatf("vec%0d_re", i), {31'd0, bus_re}, {31'd0, tbl[i].e_re});
            chk($sformatf("vec%0d_we", i), {31'd0, bus_we}, 32'd0);
            chk($sformatf("vec%0d_addr", i), bus_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_byteen", i), {28'd0, bus_byteen}, tbl[i].e_re ? 32'hF : 32'h0);
            chk($sformatf("vec%0d_ack", i), {30'd0, m0_ack, m1_ack}, {30'd0, tbl[i].e_a0, tbl[i].e_a1});
            chk($sformatf("vec%0d_err", i), {30'd0, m0_err, m1_err}, 32'd0);
            if (tbl[i].e_re && (tbl[i].e_a0 || tbl[i].e_a1)) push_rd(tbl[i].e_a1, tbl[i].dout);
        end

        // m1 write with three wait states.
        do_reset();
        m1_we = 1'b1; m1_wdata = 32'h12345678; m1_byteen = 4'b0011;
        cyc(0, 1, 0, 32'h0);
        chk("wr_idle_we", {31'd0, bus_we}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 1, k == 4, 32'h0);
            chk($sformatf("wr_b%0d_we", k), {31'd0, bus_we, bus_re}, 32'd2);
            chk($sformatf("wr_b%0d_byteen", k), {28'd0, bus_byteen}, 32'h3);
            chk($sformatf("wr_b%0d_data", k), bus_data_in, 32'h12345678);
            chk($sformatf("wr_b%0d_addr", k), bus_addr, 32'h200);
            chk($sformatf("wr_b%0d_ack", k), {30'd0, m1_ack, m0_ack}, (k == 4) ? 32'd2 : 32'd0);
        end
        cyc(0, 0, 0, 32'h0);
        chk("wr_turn", {29'd0, bus_we, m1_ack, m1_err}, 32'd0);
        m1_we = 1'b0; m1_byteen = 4'hF;

        // Timeout abort on m0 with m1 pending, then m1 is served.
        do_reset();
        cyc(1, 0, 1, 32'h55AA55AA);
        cyc(1, 0, 1, 32'h55AA55AA);
        chk("to_pre_ack", {31'd0, m0_ack}, 32'd1);
        push_rd(1'b0, 32'h55AA55AA);
        cyc(0, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 1, 0, 32'hFFFFFFFF);
            chk($sformatf("to_b%0d_addr", k), bus_addr, 32'h100);
            chk($sformatf("to_b%0d_err", k), {30'd0, m0_err, m1_err}, (k == 4) ? 32'd2 : 32'd0);
            chk($sformatf("to_b%0d_ack", k), {30'd0, m0_ack, m1_ack}, 32'd0);
        end
        cyc(0, 1, 0, 32'h0);
        chk("to_turn_err", {30'd0, m0_err, bus_re}, 32'd0);
        chk("to_rdata_kept", m0_rdata, 32'h55AA55AA);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 1, 32'h00000077);
        chk("to_m1_addr", bus_addr, 32'h200);
        chk("to_m1_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
        push_rd(1'b1, 32'h00000077);
        cyc(0, 0, 0, 32'h0);

        // bus_ready arrives exactly as the timeout expires: ack only.
        cyc(1, 0, 0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 0, k == 4, 32'hC0FFEE00);
            chk($sformatf("race_b%0d_ack", k), {30'd0, m0_ack, m0_err}, (k == 4) ? 32'd2 : 32'd0);
        end
        push_rd(1'b0, 32'hC0FFEE00);
        cyc(0, 0, 0, 32'h0);
        chk("race_turn_err", {31'd0, m0_err}, 32'd0);

        // Asynchronous reset in the middle of a BUSY cycle.
        cyc(1, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        chk("ar_busy_re", {31'd0, bus_re}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_bus_re", {31'd0, bus_re}, 32'd0);
        chk("ar_bus_addr", bus_addr, 32'd0);
        chk("ar_byteen", {28'd0, bus_byteen}, 32'd0);
        chk("ar_rdata", m0_rdata | m1_rdata, 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 32'h0);
            chk($sformatf("ar_post%0d", k), {27'd0, m0_ack, m0_err, m1_ack, m1_err, bus_re}, 32'd0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
